result_to_bcd: RTL and testbench
================================

RESULT_TO_BCD -- requirements
Module: result_to_bcd

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clk and rst_n are the port names.
REQ-002 Parameter IN_WIDTH, default 20: width of the binary result word consumed from the ALU stage.
REQ-003 Parameter DIGITS, default 7: number of BCD digits produced, sufficient for 2^IN_WIDTH-1.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  upstream presents a result word.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  IN_WIDTH  binary result from the ALU stage.
REQ-009 in_signed  input  1  1 = interpret in_data as two's complement; 0 = unsigned.
REQ-010 out_valid  output  1  conversion result available.
REQ-011 out_ready  input  1  downstream (display driver) accepts the result.
REQ-012 out_bcd  output  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0].
REQ-013 out_neg  output  1  result was negative (signed mode only).
REQ-014 busy  output  1  high while in SHIFT state.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; busy = 1 only in SHIFT; out_valid = 1 only in DONE.
REQ-016 IDLE -> SHIFT on in_valid & in_ready; the word, in_signed and the shift counter (= IN_WIDTH) are captured at that edge.
REQ-017 At capture, if in_signed = 1 and in_data MSB = 1, magnitude = two's-complement negation of in_data (IN_WIDTH bits) and neg flag = 1; otherwise magnitude = in_data and neg flag = 0.
REQ-018 Negation of the most negative value (1 followed by zeros) SHALL yield magnitude 2^(IN_WIDTH-1) as an unsigned value, not overflow.
REQ-019 Each SHIFT cycle: every BCD digit >= 5 gets +3, then the {BCD, magnitude} register shifts left one bit, MSB of magnitude entering digit 0 bit 0; counter decrements.
REQ-020 SHIFT -> DONE on the cycle the counter reaches zero; SHIFT lasts exactly IN_WIDTH cycles.
REQ-021 Latency: out_valid SHALL rise exactly IN_WIDTH+1 cycles after the accepting edge (20+1 = 21 at defaults).
REQ-022 In DONE, out_bcd and out_neg SHALL hold stable until out_valid & out_ready; DONE -> IDLE on that edge.
REQ-023 in_ready SHALL be 0 in the DONE handshake cycle; no same-cycle bypass; maximum throughput is one word per IN_WIDTH+2 cycles.
REQ-024 in_valid asserted outside IDLE SHALL be ignored; in_data changes during SHIFT SHALL not affect the result.
REQ-025 Every BCD digit of out_bcd SHALL be in range 0-9; out_neg SHALL be 0 whenever in_signed was 0 or magnitude is zero.

Reset
REQ-026 When rst_n = 0 at a clock edge: state = IDLE, BCD register = 0, magnitude = 0, counter = 0, neg flag = 0.
REQ-027 Output values in reset: in_ready = 1 after the reset edge, out_valid = 0, busy = 0, out_bcd = 0, out_neg = 0.
REQ-028 Reset during SHIFT or DONE SHALL abort and discard the conversion; no out_valid for that word.

Structure
REQ-029 A shared package SHALL hold the IN_WIDTH and DIGITS defaults and the FSM state enum typedef (IDLE, SHIFT, DONE).
REQ-030 A combinational sub-module bcd_digit_adjust (4-bit in, 4-bit out, +3 when >= 5) SHALL be instantiated once per digit.
REQ-031 Counter width SHALL be $clog2(IN_WIDTH+1) bits.

Verification
REQ-032 Unsigned in_data = 0 -> after 21 cycles out_valid, out_bcd = 0x0000000, out_neg = 0.
REQ-033 Unsigned in_data = 0xFFFFF -> out_bcd = 0x1048575, out_neg = 0, out_valid exactly 21 cycles after accept.
REQ-034 Signed in_data = 0xFFFFD (ALU 2-5) -> out_bcd = 0x0000003, out_neg = 1; signed 0x80000 -> out_bcd = 0x0524288, out_neg = 1.
REQ-035 out_ready held 0 for 10 cycles after out_valid with in_data = 0x000F0 -> out_bcd = 0x0000240 stable, in_ready = 0 throughout; release -> IDLE next cycle.
REQ-036 rst_n pulsed low at SHIFT cycle 8 -> next cycle in_ready = 1, out_valid = 0; new word 0x00017 converts to 0x0000023 normally.
REQ-037 Back-to-back in_valid held high with 5 words -> each accepted only in IDLE, results match a reference model, in order.

Source files
------------

// File: rtl/result_to_bcd_pkg.sv
// Shared defaults and FSM state type for the binary-result to BCD converter.
package result_to_bcd_pkg;

    localparam int DEF_IN_WIDTH = 20;
    localparam int DEF_DIGITS   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/result_to_bcd.sv
// Converts a signed or unsigned ALU result word into packed BCD digits plus a sign flag,
// one magnitude bit per cycle (shift-and-add-3).
module result_to_bcd
    import result_to_bcd_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int DIGITS   = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  busy,
    output state_e                state_dbg
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_e              state_q, state_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [IN_WIDTH-1:0] mag_q, mag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                in_is_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    assign in_is_neg = in_signed & in_data[IN_WIDTH-1];

    // Valid/ready: a word moves on a rising edge where valid and ready are both high;
    // out_valid with out_bcd/out_neg stays asserted and unchanged until that edge.
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Negating 100..0 gives 100..0 again, which read unsigned is the right magnitude.
                    mag_d   = in_is_neg ? (~in_data + IN_WIDTH'(1)) : in_data;
                    neg_d   = in_is_neg;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(IN_WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[IN_WIDTH-1]};
                mag_d = {mag_q[IN_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;
    assign out_neg   = neg_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_result_to_bcd.sv
// Self-checking bench for result_to_bcd: directed corner words, handshake hold, mid-conversion
// reset, back-to-back stream and random words against a decimal-arithmetic reference model.
module tb_result_to_bcd;
    import result_to_bcd_pkg::*;

    localparam int W = 20;
    localparam int D = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [4*D-1:0] out_bcd;
    logic          out_neg;
    logic          busy;
    state_e        state_dbg;

    int errors = 0;
    int checks = 0;
    logic [4*D:0] exp_q[$];

    always #5 clk = ~clk;

    result_to_bcd #(.IN_WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_neg   (out_neg),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sign/magnitude by integer arithmetic, digits by repeated division by ten.
    function automatic logic [4*D:0] model(input logic [W-1:0] d, input logic s);
        logic [4*D-1:0] b;
        int unsigned    mag;
        logic           neg;
        neg = s && (d >= (W'(1) << (W - 1)));
        mag = neg ? ((32'd1 << W) - 32'(d)) : 32'(d);
        b = '0;
        for (int i = 0; i < D; i++) begin
            b[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {neg, b};
    endfunction

    task automatic run_one(input logic [W-1:0] d, input logic s, input logic [4*D:0] e,
                           input int hold, input string tag);
        int edges;
        int wait_n;
        @(negedge clk);
        wait_n = 0;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'({busy, in_ready, out_valid}), 64'(3'b100));
        while (!out_valid && edges < 60) begin
            in_data   = W'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            in_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(edges), 64'(W + 1));
        check({tag, "_bcd"}, 64'({out_neg, out_bcd}), 64'(e));
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold"}, 64'({out_valid, in_ready, out_neg, out_bcd}), 64'({2'b10, e}));
            in_data  = W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
    endtask

    task automatic back_to_back();
        logic [W-1:0] words[5];
        logic         sg[5];
        logic [4*D:0] e;
        int           idx;
        int           got;
        int           cyc;
        int           last_acc;
        bit           acc;
        for (int i = 0; i < 5; i++) begin
            words[i] = W'($urandom);
            sg[i]    = 1'($urandom_range(0, 1));
        end
        idx = 0;
        got = 0;
        cyc = 0;
        last_acc = -1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = words[0];
        in_signed = sg[0];
        while (got < 5 && cyc < 400) begin
            acc = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("b2b_bcd", 64'({out_neg, out_bcd}), 64'(e));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_signed));
                if (last_acc >= 0) check("b2b_gap", 64'(cyc - last_acc), 64'(W + 2));
                last_acc = cyc;
                acc = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 5) begin
                    in_data   = words[idx];
                    in_signed = sg[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 64'(got), 64'(5));
        check("b2b_queue_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic reset_mid(input int cycles_in, input string tag);
        int seen;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 20'hABCDE;
        in_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (cycles_in - 1) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check({tag, "_after_reset"}, 64'({in_ready, out_valid, busy, out_neg, out_bcd}),
              64'({4'b1000, 28'h0}));
        check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check({tag, "_no_valid"}, 64'(seen), 64'(0));
    endtask

    initial begin
        logic [W-1:0] d;
        logic         s;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({in_ready, out_valid, busy, out_neg, out_bcd}),
              64'({4'b1000, 28'h0}));
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        rst_n = 1'b1;

        run_one(20'h00000, 1'b0, {1'b0, 28'h0000000}, 0, "zero");
        run_one(20'hFFFFF, 1'b0, {1'b0, 28'h1048575}, 0, "max_unsigned");
        run_one(20'hFFFFD, 1'b1, {1'b1, 28'h0000003}, 1, "minus3");
        run_one(20'h80000, 1'b1, {1'b1, 28'h0524288}, 0, "most_negative");
        run_one(20'h80000, 1'b0, {1'b0, 28'h0524288}, 0, "half_unsigned");
        run_one(20'h7FFFF, 1'b1, {1'b0, 28'h0524287}, 0, "max_signed");
        run_one(20'h00000, 1'b1, {1'b0, 28'h0000000}, 0, "zero_signed");
        run_one(20'h000F0, 1'b0, {1'b0, 28'h0000240}, 10, "hold240");

        reset_mid(8, "abort_shift");
        run_one(20'h00017, 1'b0, {1'b0, 28'h0000023}, 0, "after_abort");

        reset_mid(W + 2, "abort_done");
        run_one(20'h12345, 1'b0, model(20'h12345, 1'b0), 0, "after_done_abort");

        back_to_back();

        for (int i = 0; i < 20; i++) begin
            d = W'($urandom);
            s = 1'($urandom_range(0, 1));
            run_one(d, s, model(d, s), $urandom_range(0, 3), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
